line_err_sel: RTL and testbench

LINE_ERR_SEL -- requirements
Module: line_err_sel

---
 rtl/line_err_sel.sv | 150 +++++++++++++++
 tb/tb_line_err_sel.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/line_err_sel.sv
// Line error selector: differential IR accumulation with TRACK/LOST hysteresis.
// Latency NCH+2 clocks from accepted ir_vld to err_vld.
// ir_vld arriving while busy is dropped and flagged by sticky overrun.
module line_err_sel #(
  parameter int NCH      = 4,
  parameter int DW       = 12,
  parameter int EW       = 16,
  parameter int LOSS_CNT = 3,
  parameter int ACQ_CNT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ir_vld,
  input  logic [NCH*DW-1:0]   ir_l,
  input  logic [NCH*DW-1:0]   ir_r,
  input  logic [DW-1:0]       line_thresh,
  input  logic [EW-1:0]       err_opn_lp,
  output logic [EW-1:0]       error,
  output logic                err_vld,
  output logic                line_present,
  output logic                overrun
);

  // Accumulator holds sum of (R-L)<<k; |sum| < 2^(DW+NCH), so one sign bit suffices.
  localparam int AW = DW + NCH + 1;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MW = (AW > EW) ? AW : EW;
  localparam logic signed [MW-1:0] SAT_MAX = {{(MW-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {{(MW-EW+1){1'b1}}, {(EW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                state;
  logic [NCH*DW-1:0]     cap_l;
  logic [NCH*DW-1:0]     cap_r;
  logic signed [AW-1:0]  acc;
  logic [IW-1:0]         idx;
  logic                  seen;
  logic [3:0]            loss_cnt;
  logic [3:0]            acq_cnt;

  logic [DW-1:0]         cur_l;
  logic [DW-1:0]         cur_r;
  logic signed [AW-1:0]  diff;
  logic signed [AW-1:0]  term;
  logic                  ch_seen;
  logic signed [MW-1:0]  acc_x;
  logic [EW-1:0]         sat;
  logic                  mode_nxt;
  logic [3:0]            loss_nxt;
  logic [3:0]            acq_nxt;

  // Per-channel contribution and threshold test for the channel selected by idx.
  always_comb begin
    cur_l   = cap_l[idx*DW +: DW];
    cur_r   = cap_r[idx*DW +: DW];
    diff    = $signed({{(AW-DW){1'b0}}, cur_r}) - $signed({{(AW-DW){1'b0}}, cur_l});
    term    = diff <<< idx;
    ch_seen = (cur_l > line_thresh) || (cur_r > line_thresh);
  end

  // Saturate the accumulated result into the EW-bit signed error range.
  always_comb begin
    acc_x = MW'(acc);
    if (acc_x > SAT_MAX)
      sat = SAT_MAX[EW-1:0];
    else if (acc_x < SAT_MIN)
      sat = SAT_MIN[EW-1:0];
    else
      sat = acc_x[EW-1:0];
  end

  // Mode hysteresis: the sample completing a count already uses the new mode.
  always_comb begin
    mode_nxt = line_present;
    loss_nxt = loss_cnt;
    acq_nxt  = acq_cnt;
    if (line_present) begin
      if (seen) begin
        loss_nxt = 4'd0;
      end else if (loss_cnt + 4'd1 == 4'(LOSS_CNT)) begin
        mode_nxt = 1'b0;
        loss_nxt = 4'd0;
      end else begin
        loss_nxt = loss_cnt + 4'd1;
      end
    end else begin
      if (!seen) begin
        acq_nxt = 4'd0;
      end else if (acq_cnt + 4'd1 == 4'(ACQ_CNT)) begin
        mode_nxt = 1'b1;
        acq_nxt  = 4'd0;
      end else begin
        acq_nxt = acq_cnt + 4'd1;
      end
    end
  end

  // Capture / accumulate / publish sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cap_l        <= '0;
      cap_r        <= '0;
      acc          <= '0;
      idx          <= '0;
      seen         <= 1'b0;
      loss_cnt     <= 4'd0;
      acq_cnt      <= 4'd0;
      error        <= '0;
      err_vld      <= 1'b0;
      line_present <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      err_vld <= 1'b0;
      if (ir_vld && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (ir_vld) begin
            cap_l <= ir_l;
            cap_r <= ir_r;
            acc   <= '0;
            idx   <= '0;
            seen  <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc  <= acc + term;
          seen <= seen | ch_seen;
          if (idx == IW'(NCH - 1))
            state <= DONE;
          else
            idx <= idx + IW'(1);
        end
        DONE: begin
          line_present <= mode_nxt;
          loss_cnt     <= loss_nxt;
          acq_cnt      <= acq_nxt;
          error        <= mode_nxt ? sat : err_opn_lp;
          err_vld      <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_err_sel.sv
// Directed bench for line_err_sel: scoreboard of expected error/line_present
// pushed at stimulus time and popped at each err_vld.
module tb_line_err_sel;
  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int EW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ir_vld;
  logic [NCH*DW-1:0] ir_l;
  logic [NCH*DW-1:0] ir_r;
  logic [DW-1:0]     line_thresh;
  logic [EW-1:0]     err_opn_lp;
  logic [EW-1:0]     error;
  logic              err_vld;
  logic              line_present;
  logic              overrun;

  typedef struct packed {
    logic [EW-1:0] err;
    logic          lp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  line_err_sel #(.NCH(NCH), .DW(DW), .EW(EW), .LOSS_CNT(3), .ACQ_CNT(2)) dut (
    .clk(clk), .rst(rst), .ir_vld(ir_vld), .ir_l(ir_l), .ir_r(ir_r),
    .line_thresh(line_thresh), .err_opn_lp(err_opn_lp),
    .error(error), .err_vld(err_vld), .line_present(line_present), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH*DW-1:0] ch(input int i, input logic [DW-1:0] v);
    logic [NCH*DW-1:0] x;
    x = '0;
    x[i*DW +: DW] = v;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one sample and checks its result.
  // b2b=1 returns at the err_vld edge so the next sample is driven immediately.
  task automatic send(input logic [NCH*DW-1:0] l, input logic [NCH*DW-1:0] r,
                      input logic [EW-1:0] opn, input logic [EW-1:0] exp_err,
                      input logic exp_lp, input bit b2b);
    exp_t e;
    int   lat;
    bit   got;
    e.err = exp_err;
    e.lp  = exp_lp;
    sb.push_back(e);
    ir_l = l; ir_r = r; err_opn_lp = opn; ir_vld = 1'b1;
    @(negedge clk);
    ir_vld = 1'b0;
    lat = 1;
    got = 0;
    while (!got && lat < 20) begin
      if (err_vld) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!got) begin
      chk("err_vld_timeout", 32'(got), 32'd1);
      void'(sb.pop_front());
    end else begin
      chk("latency", 32'(lat), 32'(NCH + 2));
      e = sb.pop_front();
      chk("error", 32'(error), 32'(e.err));
      chk("line_present", 32'(line_present), 32'(e.lp));
      if (!b2b) begin
        @(negedge clk);
        chk("err_vld_width", 32'(err_vld), 32'd0);
        chk("error_hold", 32'(error), 32'(e.err));
      end
    end
  endtask

  initial begin
    exp_t e;
    int   pulses;
    int   vld_seen;
    logic [EW-1:0] first_err;
    logic          first_lp;

    rst = 1'b1; ir_vld = 1'b0; ir_l = '0; ir_r = '0;
    line_thresh = 12'h080; err_opn_lp = '0;
    repeat (3) @(negedge clk);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_vld", 32'(err_vld), 32'd0);
    chk("rst_line_present", 32'(line_present), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    // Acquisition from reset needs two line samples.
    send('0, ch(0, 12'h100), 16'h0123, 16'h0123, 1'b0, 0);
    send('0, ch(0, 12'h100), 16'h0123, 16'h0100, 1'b1, 0);
    // Saturation at both ends and weighted outer channel.
    send('0, {NCH{12'hFFF}}, 16'h0123, 16'h7FFF, 1'b1, 0);
    send({NCH{12'hFFF}}, '0, 16'h0123, 16'h8000, 1'b1, 0);
    send(ch(3, 12'h200), '0, 16'h0123, 16'hF000, 1'b1, 0);
    // Line loss after three empty samples, issued back-to-back.
    send('0, '0, 16'h0040, 16'h0000, 1'b1, 1);
    send('0, '0, 16'h0040, 16'h0000, 1'b1, 1);
    send('0, '0, 16'h0040, 16'h0040, 1'b0, 0);
    // Sample equal to threshold is not a line.
    send('0, ch(0, 12'h080), 16'h0040, 16'h0040, 1'b0, 0);
    // Line / no-line / line keeps LOST; second consecutive line reacquires.
    send('0, ch(0, 12'h100), 16'h0040, 16'h0040, 1'b0, 0);
    send('0, '0, 16'h0040, 16'h0040, 1'b0, 0);
    send(ch(0, 12'h081), '0, 16'h0055, 16'h0055, 1'b0, 0);
    send('0, ch(0, 12'h100), 16'h0040, 16'h0100, 1'b1, 0);
    chk("overrun_clear", 32'(overrun), 32'd0);

    // Overrun: second ir_vld two cycles after an accepted one is dropped.
    e.err = 16'h0020; e.lp = 1'b1;
    sb.push_back(e);
    ir_l = '0; ir_r = ch(1, 12'h010); err_opn_lp = 16'h0040; ir_vld = 1'b1;
    @(negedge clk); ir_vld = 1'b0;
    @(negedge clk); ir_l = '0; ir_r = {NCH{12'hFFF}}; ir_vld = 1'b1;
    @(negedge clk); ir_vld = 1'b0;
    pulses = 0; first_err = '0; first_lp = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (err_vld) begin
        if (pulses == 0) begin first_err = error; first_lp = line_present; end
        pulses++;
      end
      @(negedge clk);
    end
    chk("overrun_pulses", 32'(pulses), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("overrun_error", 32'(first_err), 32'(e.err));
      chk("overrun_lp", 32'(first_lp), 32'(e.lp));
    end
    chk("overrun_set", 32'(overrun), 32'd1);
    send('0, ch(0, 12'h100), 16'h0040, 16'h0100, 1'b1, 0);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of accumulation aborts the sample.
    ir_l = '0; ir_r = ch(0, 12'h100); ir_vld = 1'b1;
    @(negedge clk); ir_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_error", 32'(error), 32'd0);
    chk("mid_rst_lp", 32'(line_present), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_err_vld", 32'(err_vld), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vld_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (err_vld) vld_seen++;
    end
    chk("no_vld_after_rst", 32'(vld_seen), 32'd0);
    send('0, ch(0, 12'h100), 16'h0077, 16'h0077, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
